// File: rtl/nes_frame_reader.sv
// Pull-driven pixel source: 2x-scaled, horizontally centred NES framebuffer with palette lookup.
// One-column prefetch (plus a bypass of the returning RAM data) hides the 1-cycle RAM latency.
module nes_frame_reader #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_OFFSET   = 64,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic        i_pixclk,
    input  logic        i_reset,
    input  logic        i_rd,
    input  logic        i_newline,
    input  logic        i_newframe,
    output logic [23:0] o_pixel,
    output logic [15:0] o_fb_addr,
    input  logic [5:0]  i_fb_data,
    output logic        o_frame_start
);

    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 9;
    localparam int unsigned IMG_W = 512;
    localparam logic [5:0]  IDX_BLACK = 6'h0F;
    // Column tag that no image column matches; parks the prefetch after reset
    localparam logic [8:0]  COL_NONE  = 9'd256;

    logic [XW-1:0] x;
    logic [XW-1:0] next_x;
    logic [YW-1:0] y;
    logic [YW-1:0] next_y;
    logic [8:0]    pre_col;
    logic [5:0]    cur_idx;
    logic [5:0]    nxt_idx;
    logic          req;
    logic          req_d;

    logic          in_img;
    logic [7:0]    next_col;
    logic          enter;
    logic [5:0]    eff_nxt;
    logic [5:0]    pix_idx;
    logic          restart;

    function automatic logic [23:0] palette(input logic [5:0] idx);
        logic [23:0] p;
        p = 24'h000000;
        case (idx)
            6'h00: p = 24'h7C7C7C; 6'h01: p = 24'h0000FC; 6'h02: p = 24'h0000BC; 6'h03: p = 24'h4428BC;
            6'h04: p = 24'h940084; 6'h05: p = 24'hA80020; 6'h06: p = 24'hA81000; 6'h07: p = 24'h881400;
            6'h08: p = 24'h503000; 6'h09: p = 24'h007800; 6'h0A: p = 24'h006800; 6'h0B: p = 24'h005800;
            6'h0C: p = 24'h004058; 6'h0D: p = 24'h000000; 6'h0E: p = 24'h000000; 6'h0F: p = 24'h000000;
            6'h10: p = 24'hBCBCBC; 6'h11: p = 24'h0078F8; 6'h12: p = 24'h0058F8; 6'h13: p = 24'h6844FC;
            6'h14: p = 24'hD800CC; 6'h15: p = 24'hE40058; 6'h16: p = 24'hF83800; 6'h17: p = 24'hE45C10;
            6'h18: p = 24'hAC7C00; 6'h19: p = 24'h00B800; 6'h1A: p = 24'h00A800; 6'h1B: p = 24'h00A844;
            6'h1C: p = 24'h008888; 6'h1D: p = 24'h000000; 6'h1E: p = 24'h000000; 6'h1F: p = 24'h000000;
            6'h20: p = 24'hF8F8F8; 6'h21: p = 24'h3CBCFC; 6'h22: p = 24'h6888FC; 6'h23: p = 24'h9878F8;
            6'h24: p = 24'hF878F8; 6'h25: p = 24'hF85898; 6'h26: p = 24'hF87858; 6'h27: p = 24'hFCA044;
            6'h28: p = 24'hF8B800; 6'h29: p = 24'hB8F818; 6'h2A: p = 24'h58D854; 6'h2B: p = 24'h58F898;
            6'h2C: p = 24'h00E8D8; 6'h2D: p = 24'h787878; 6'h2E: p = 24'h000000; 6'h2F: p = 24'h000000;
            6'h30: p = 24'hFCFCFC; 6'h31: p = 24'hA4E4FC; 6'h32: p = 24'hB8B8F8; 6'h33: p = 24'hD8B8F8;
            6'h34: p = 24'hF8B8F8; 6'h35: p = 24'hF8A4C0; 6'h36: p = 24'hF0D0B0; 6'h37: p = 24'hFCE0A8;
            6'h38: p = 24'hF8D878; 6'h39: p = 24'hD8F878; 6'h3A: p = 24'hB8F8B8; 6'h3B: p = 24'hB8F8D8;
            6'h3C: p = 24'h00FCFC; 6'h3D: p = 24'hF8D8F8; 6'h3E: p = 24'h000000; 6'h3F: p = 24'h000000;
            default: p = 24'h000000;
        endcase
        return p;
    endfunction

    // Position update; newframe beats newline beats rd
    always_comb begin
        next_x = x;
        next_y = y;
        if (i_newframe) begin
            next_x = '0;
            next_y = '0;
        end else if (i_newline) begin
            next_x = '0;
            if (y != YW'(V_ACTIVE - 1)) next_y = y + 9'd1;
        end else if (i_rd && (x != XW'(H_ACTIVE - 1))) begin
            next_x = x + 10'd1;
        end
    end

    // Column selection for the upcoming position; entering the prefetched column uses
    // the returning RAM word directly when it is arriving on this very edge
    always_comb begin
        restart  = i_newframe | i_newline;
        in_img   = (next_x >= XW'(H_OFFSET)) && (next_x < XW'(H_OFFSET + IMG_W));
        next_col = 8'((next_x - XW'(H_OFFSET)) >> 1);
        enter    = in_img && ({1'b0, next_col} == pre_col);
        eff_nxt  = req_d ? i_fb_data : nxt_idx;
        pix_idx  = enter ? eff_nxt : cur_idx;
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            x             <= '0;
            y             <= '0;
            o_pixel       <= BORDER_RGB;
            o_fb_addr     <= '0;
            o_frame_start <= 1'b0;
            cur_idx       <= IDX_BLACK;
            nxt_idx       <= IDX_BLACK;
            pre_col       <= COL_NONE;
            req           <= 1'b0;
            req_d         <= 1'b0;
        end else begin
            x             <= next_x;
            y             <= next_y;
            o_frame_start <= i_newframe;
            o_pixel       <= in_img ? palette(pix_idx) : BORDER_RGB;
            req           <= 1'b0;
            req_d         <= req;
            if (req_d) nxt_idx <= i_fb_data;
            if (restart) begin
                pre_col   <= 9'd0;
                o_fb_addr <= {next_y[8:1], 8'd0};
                req       <= 1'b1;
            end else if (enter) begin
                cur_idx <= eff_nxt;
                pre_col <= {1'b0, next_col} + 9'd1;
                // Past the last column the address simply holds
                if (next_col != 8'hFF) begin
                    o_fb_addr <= {next_y[8:1], next_col + 8'd1};
                    req       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nes_frame_reader.sv
// Directed self-checking bench for nes_frame_reader with a 1-cycle-latency framebuffer model.
module tb_nes_frame_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        newline;
    logic        newframe;
    logic [23:0] pixel;
    logic [15:0] fb_addr;
    logic [5:0]  fb_data;
    logic        frame_start;

    int          checks = 0;
    int          errors = 0;
    logic        uniform = 1'b0;
    logic [23:0] pal [64];

    nes_frame_reader dut (
        .i_pixclk      (clk),
        .i_reset       (reset),
        .i_rd          (rd),
        .i_newline     (newline),
        .i_newframe    (newframe),
        .o_pixel       (pixel),
        .o_fb_addr     (fb_addr),
        .i_fb_data     (fb_data),
        .o_frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // fb[r][c] = (r + c) & 0x3F, or a uniform 0x30 fill
    always @(posedge clk) fb_data <= uniform ? 6'h30 : 6'(fb_addr[15:8] + fb_addr[7:0]);

    function automatic logic [23:0] expect_rgb(input int xx, input int row);
        if (xx < 64 || xx >= 576) return 24'h000000;
        if (uniform) return pal[6'h30];
        return pal[(row + (xx - 64) / 2) & 63];
    endfunction

    task tick();
        @(posedge clk);
        #1;
    endtask

    task pulse(input logic nf, input logic nl, input logic r);
        newframe = nf;
        newline  = nl;
        rd       = r;
        tick();
        newframe = 1'b0;
        newline  = 1'b0;
        rd       = 1'b0;
    endtask

    // One idle cycle, then 640 back-to-back reads checked before each accepting edge
    task run_line(input int row, input string tag, input int ax, input logic [23:0] aval);
        tick();
        for (int xx = 0; xx < 640; xx++) begin
            rd = 1'b1;
            checks++;
            if (pixel !== expect_rgb(xx, row)) begin
                errors++;
                $display("FAIL %s x=%0d: o_pixel=%h expected %h", tag, xx, pixel, expect_rgb(xx, row));
            end
            if (xx == ax) begin
                checks++;
                if (pixel !== aval) begin
                    errors++;
                    $display("FAIL %s anchor x=%0d: o_pixel=%h expected %h", tag, xx, pixel, aval);
                end
            end
            tick();
        end
        rd = 1'b0;
        checks++;
        if (pixel !== 24'h000000) begin
            errors++;
            $display("FAIL %s end-of-line: o_pixel=%h expected 000000", tag, pixel);
        end
    endtask

    task test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks += 3;
            if (pixel !== 24'h000000) begin
                errors++;
                $display("FAIL reset pixel: got %h expected 000000", pixel);
            end
            if (fb_addr !== 16'h0000) begin
                errors++;
                $display("FAIL reset fb_addr: got %h expected 0000", fb_addr);
            end
            if (frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset frame_start: got %b expected 0", frame_start);
            end
        end
    endtask

    task test_line();
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL line frame_start: got %b expected 1", frame_start);
        end
        run_line(0, "row0", 64, 24'h7C7C7C);
    endtask

    task test_newline();
        repeat (3) pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (fb_addr !== 16'h0100) begin
            errors++;
            $display("FAIL newline fb_addr: got %h expected 0100", fb_addr);
        end
        run_line(1, "row1", 64, 24'h0000FC);
    endtask

    task test_simultaneous();
        pulse(1'b0, 1'b1, 1'b0);
        rd = 1'b1;
        repeat (300) tick();
        rd = 1'b0;
        pulse(1'b1, 1'b1, 1'b1);
        checks += 3;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL simul frame_start: got %b expected 1", frame_start);
        end
        if (fb_addr !== 16'h0000) begin
            errors++;
            $display("FAIL simul fb_addr: got %h expected 0000", fb_addr);
        end
        if (pixel !== 24'h000000) begin
            errors++;
            $display("FAIL simul pixel: got %h expected 000000", pixel);
        end
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL simul frame_start second cycle: got %b expected 0", frame_start);
        end
        newframe = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (frame_start !== 1'b1) begin
                errors++;
                $display("FAIL b2b frame_start %0d: got %b expected 1", i, frame_start);
            end
        end
        newframe = 1'b0;
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL b2b frame_start end: got %b expected 0", frame_start);
        end
        run_line(0, "simul_row0", 67, 24'h0000FC);
    endtask

    task test_reset_midline();
        uniform = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        rd = 1'b1;
        repeat (300) tick();
        rd = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 3;
        if (pixel !== 24'h000000) begin
            errors++;
            $display("FAIL midreset pixel: got %h expected 000000", pixel);
        end
        if (fb_addr !== 16'h0000) begin
            errors++;
            $display("FAIL midreset fb_addr: got %h expected 0000", fb_addr);
        end
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset frame_start: got %b expected 0", frame_start);
        end
        repeat (2) tick();
        pulse(1'b1, 1'b0, 1'b0);
        run_line(0, "uniform", 64, 24'hFCFCFC);
        uniform = 1'b0;
    endtask

    task test_saturation();
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        rd = 1'b1;
        repeat (700) tick();
        checks++;
        if (pixel !== 24'h000000) begin
            errors++;
            $display("FAIL xsat 700: o_pixel=%h expected 000000", pixel);
        end
        repeat (400) tick();
        rd = 1'b0;
        checks++;
        if (pixel !== 24'h000000) begin
            errors++;
            $display("FAIL xsat 1100: o_pixel=%h expected 000000", pixel);
        end
        repeat (500) pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (fb_addr !== 16'hEF00) begin
            errors++;
            $display("FAIL ysat fb_addr: got %h expected EF00", fb_addr);
        end
        run_line(239, "row239", 66, 24'hFCFCFC);
    endtask

    initial begin
        pal = '{
            24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
            24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
            24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
            24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
            24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
            24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
            24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
            24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
        };
        reset    = 1'b1;
        rd       = 1'b0;
        newline  = 1'b0;
        newframe = 1'b0;
        test_reset();
        test_line();
        test_newline();
        test_simultaneous();
        test_reset_midline();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_frame_reader.md
# nes_frame_reader

Pixel source that answers the HDMI encoder's pull requests (`rd` / `newline` / `newframe`). It reads 6-bit NES palette indices from a 256×240 framebuffer RAM and scales them 2× in both directions. The result is centred horizontally in the 640×480 active window and converted to 24-bit RGB through the internal NES palette. It is the drop-in replacement for the test-pattern source and sits between the PPU framebuffer and the HDMI encoder in the pixel-clock domain.

## Interface
Parameters
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `H_OFFSET`, 64: first active x showing image; image spans x = 64..575.
- `BORDER_RGB`, 24'h000000: colour outside the image window.

Ports
- `i_pixclk`, in, 1: pixel clock (25 MHz); the only clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_rd`, in, 1: consume current pixel; advance x.
- `i_newline`, in, 1: set x = 0, y = y + 1.
- `i_newframe`, in, 1: set x = 0, y = 0.
- `o_pixel`, out, 24: {R, G, B} for the current (x, y).
- `o_fb_addr`, out, 16: framebuffer read address = {row[7:0], col[7:0]}.
- `i_fb_data`, in, 6: palette index; valid exactly 1 cycle after `o_fb_addr`.
- `o_frame_start`, out, 1: 1-cycle pulse on the cycle after `i_newframe` is accepted.

## Operation
- Position counters: x is 10 bits and y is 9 bits.
  - `i_rd` increments x, saturating at `H_ACTIVE-1`.
  - `i_newline` increments y, saturating at `V_ACTIVE-1`, and clears x.
- Priority when events coincide on the same edge: `i_newframe` > `i_newline` > `i_rd`.
  - `i_newframe` with `i_newline` gives (0, 0).
  - `i_newline` with `i_rd` gives x = 0.
- Mapping:
  - Image region: `H_OFFSET <= x < H_OFFSET+512`, with col = (x − `H_OFFSET`) >> 1 and row = y >> 1.
  - All other x output `BORDER_RGB`.
- Palette: the 64-entry team NES table, as a combinational lookup on the registered index.
  - Anchors: 0x00 → 7C7C7C, 0x0F → 000000, 0x30 → FCFCFC, 0x21 → 3CBCFC.
  - Index bits above 5 do not exist.
- Prefetch:
  - While column c is displayed, the block issues the address for column c+1 and latches the returned index into a next-pixel register.
  - Each column is shown for 2 consecutive x, so one RAM latency is always hidden.
  - On `i_newline` / `i_newframe`, the block issues the address for {new row, col 0} immediately. There are 64 border cycles of slack before col 0 is needed.
- Beyond col 255, no further reads are issued; `o_fb_addr` holds its last value.
- `o_pixel` is registered and updates the cycle after any position change.

## Timing
- Reset values:
  - x = 0, y = 0.
  - `o_pixel` = `BORDER_RGB`.
  - `o_fb_addr` = 0.
  - `o_frame_start` = 0.
  - Next-pixel and current-index registers = 0x0F.
- Reset mid-line discards the prefetch state. The first accepted `i_newframe` or `i_newline` then restarts fetching.
- Requirement: whenever `i_rd` is sampled high, `o_pixel` already equals the colour for the current (x, y).
  - This must hold for back-to-back `i_rd` on every cycle of the line.
  - The first `i_rd` must be allowed as early as 2 cycles after `i_newline`.
- Latency from a position change to updated `o_pixel` is 1 cycle. There is no stall output; the block never back-pressures.
- `i_rd` while x = `H_ACTIVE-1`: x holds and `o_pixel` stays border.
- `i_newline` while y = `V_ACTIVE-1`: y holds and row stays 239.
- `o_frame_start` fires once per accepted `i_newframe`, including back-to-back ones.

## Test plan
- Reset, then no requests:
  - `o_pixel` = 000000 and `o_fb_addr` = 0 throughout.
  - `o_frame_start` stays 0.
- Framebuffer model with fb[r][c] = (r + c) & 0x3F and 1-cycle read latency. Send `i_newframe`, then 640 back-to-back `i_rd`:
  - x 0..63 and 576..639 give 000000.
  - x = 64, 65 give palette(0x00) = 7C7C7C.
  - x = 66, 67 give palette(0x01).
  - x = 574, 575 give palette(0x3F).
- `i_newline` ×3, then the line again: row = 1, so x = 64 gives palette(0x01) and every column pair is shifted by 1.
- Simultaneous `i_newframe` + `i_newline` + `i_rd` mid-line:
  - Position becomes (0, 0).
  - `o_frame_start` pulses exactly once on the next cycle.
  - The subsequent line is row 0.
- Uniform fb 0x30; reset asserted at x = 300; `i_newframe` after reset release:
  - `o_pixel` is border for x < 64.
  - x = 64 gives FCFCFC with no stale data.
- 700 `i_rd` on one line, then 500 `i_newline`:
  - x saturates at 639 with border output.
  - y saturates at 479 and the row-239 address is used.
